// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO controller: depth helper,
// parameter legality checks and the registered status-flag bundle.
package fifo_pkg;

  localparam int C_MIN_DEPTH_BITS = 2;
  localparam int C_MAX_DEPTH_BITS = 16;

  // Status flags kept together so they are always registered as one unit.
  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  // Number of RAM entries addressed by depth_bits address lines.
  function automatic int fifo_depth(input int depth_bits);
    return 1 << depth_bits;
  endfunction

  function automatic bit depth_bits_legal(input int depth_bits);
    return (depth_bits >= C_MIN_DEPTH_BITS) && (depth_bits <= C_MAX_DEPTH_BITS);
  endfunction

  function automatic bit afull_thresh_legal(input int depth_bits, input int thresh);
    return (thresh >= 1) && (thresh <= fifo_depth(depth_bits) - 1);
  endfunction

  function automatic bit aempty_thresh_legal(input int depth_bits, input int thresh);
    return (thresh >= 0) && (thresh <= fifo_depth(depth_bits) - 2);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Binary FIFO pointer with a wrap bit: counts modulo 2**C_PTR_W so that the
// extra MSB distinguishes a full FIFO from an empty one.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int C_PTR_W = 11
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  output logic [C_PTR_W-1:0] PTR
);

  // Advance by one on each accepted access; natural overflow gives the wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PTR <= '0;
    end else if (EN) begin
      PTR <= PTR + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller for an external simple-dual-port RAM with a
// one-cycle registered read. Generates RAM addresses/enables, occupancy,
// full/empty/almost flags, read-data valid and sticky error flags.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int C_DEPTH_BITS    = 10,
  parameter int C_AFULL_THRESH  = fifo_depth(C_DEPTH_BITS) - 4,
  parameter int C_AEMPTY_THRESH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WR_EN,
  input  logic                    RD_EN,
  input  logic                    ERR_CLR,
  output logic                    RAM_WE,
  output logic [C_DEPTH_BITS-1:0] RAM_WADDR,
  output logic                    RAM_RE,
  output logic [C_DEPTH_BITS-1:0] RAM_RADDR,
  output logic                    RD_VALID,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic                    AFULL,
  output logic                    AEMPTY,
  output logic [C_DEPTH_BITS:0]   COUNT,
  output logic                    OVERFLOW,
  output logic                    UNDERFLOW
);

  localparam int CW = C_DEPTH_BITS + 1;
  localparam int D  = fifo_depth(C_DEPTH_BITS);

  localparam logic [CW-1:0] DEPTH_C  = CW'(D);
  localparam logic [CW-1:0] AFULL_C  = CW'(C_AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(C_AEMPTY_THRESH);

  // Reject illegal configurations while elaborating, before any logic exists.
  if (!depth_bits_legal(C_DEPTH_BITS)) begin : g_bad_depth
    $error("sync_fifo_ctrl: C_DEPTH_BITS=%0d outside 2..16", C_DEPTH_BITS);
  end
  if (!afull_thresh_legal(C_DEPTH_BITS, C_AFULL_THRESH)) begin : g_bad_afull
    $error("sync_fifo_ctrl: C_AFULL_THRESH=%0d outside 1..D-1", C_AFULL_THRESH);
  end
  if (!aempty_thresh_legal(C_DEPTH_BITS, C_AEMPTY_THRESH)) begin : g_bad_aempty
    $error("sync_fifo_ctrl: C_AEMPTY_THRESH=%0d outside 0..D-2", C_AEMPTY_THRESH);
  end

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nx;
  fifo_flags_t   flags_q;
  fifo_flags_t   flags_nx;
  logic          wf;
  logic          rf;
  logic          vld_p1;
  logic          ovf_q;
  logic          udf_q;

  // Accepts are qualified only by registered flags, so the sole combinational
  // path from the requests is to the RAM enables. Reset blocks both.
  assign wf = WR_EN & ~flags_q.full  & ~RST;
  assign rf = RD_EN & ~flags_q.empty & ~RST;

  assign RAM_WE    = wf;
  assign RAM_RE    = rf;
  assign RAM_WADDR = wr_ptr[C_DEPTH_BITS-1:0];
  assign RAM_RADDR = rd_ptr[C_DEPTH_BITS-1:0];

  fifo_ptr #(.C_PTR_W(CW)) u_wr_ptr (
    .CLK (CLK),
    .RST (RST),
    .EN  (wf),
    .PTR (wr_ptr)
  );

  fifo_ptr #(.C_PTR_W(CW)) u_rd_ptr (
    .CLK (CLK),
    .RST (RST),
    .EN  (rf),
    .PTR (rd_ptr)
  );

  // Next occupancy: a simultaneous write and read leaves the count unchanged.
  always_comb begin
    count_nx = count_q;
    case ({wf, rf})
      2'b10:   count_nx = count_q + 1'b1;
      2'b01:   count_nx = count_q - 1'b1;
      default: count_nx = count_q;
    endcase
  end

  // Flags derived from the next count so they line up with the updated COUNT.
  always_comb begin
    flags_nx        = '0;
    flags_nx.full   = (count_nx == DEPTH_C);
    flags_nx.empty  = (count_nx == '0);
    flags_nx.afull  = (count_nx >= AFULL_C);
    flags_nx.aempty = (count_nx <= AEMPTY_C);
  end

  // Occupancy and status register; reset shows an empty FIFO.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q        <= '0;
      flags_q.full   <= 1'b0;
      flags_q.empty  <= 1'b1;
      flags_q.afull  <= 1'b0;
      flags_q.aempty <= 1'b1;
    end else begin
      count_q <= count_nx;
      flags_q <= flags_nx;
    end
  end

  // RAM read data lands one cycle after an accepted read; reset kills it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rf;
    end
  end

  // Sticky error capture; a new violation outranks a clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (WR_EN & flags_q.full) begin
        ovf_q <= 1'b1;
      end else if (ERR_CLR) begin
        ovf_q <= 1'b0;
      end
      if (RD_EN & flags_q.empty) begin
        udf_q <= 1'b1;
      end else if (ERR_CLR) begin
        udf_q <= 1'b0;
      end
    end
  end

  assign COUNT     = count_q;
  assign FULL      = flags_q.full;
  assign EMPTY     = flags_q.empty;
  assign AFULL     = flags_q.afull;
  assign AEMPTY    = flags_q.aempty;
  assign RD_VALID  = vld_p1;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;

  // Occupancy must always equal the pointer distance and never exceed depth.
  a_count_matches_ptrs: assert property (@(posedge CLK) disable iff (RST)
    count_q == CW'(wr_ptr - rd_ptr));
  a_count_in_range: assert property (@(posedge CLK) disable iff (RST)
    count_q <= DEPTH_C);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl (16-deep configuration) with a
// behavioural RAM and a queue-based reference model of the FIFO contents.
module tb_sync_fifo_ctrl;

  localparam int DB = 4;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          WR_EN;
  logic          RD_EN;
  logic          ERR_CLR;
  logic          RAM_WE;
  logic [DB-1:0] RAM_WADDR;
  logic          RAM_RE;
  logic [DB-1:0] RAM_RADDR;
  logic          RD_VALID;
  logic          FULL;
  logic          EMPTY;
  logic          AFULL;
  logic          AEMPTY;
  logic [DB:0]   COUNT;
  logic          OVERFLOW;
  logic          UNDERFLOW;

  sync_fifo_ctrl #(
    .C_DEPTH_BITS    (DB),
    .C_AFULL_THRESH  (AF),
    .C_AEMPTY_THRESH (AE)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .WR_EN     (WR_EN),
    .RD_EN     (RD_EN),
    .ERR_CLR   (ERR_CLR),
    .RAM_WE    (RAM_WE),
    .RAM_WADDR (RAM_WADDR),
    .RAM_RE    (RAM_RE),
    .RAM_RADDR (RAM_RADDR),
    .RD_VALID  (RD_VALID),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .AFULL     (AFULL),
    .AEMPTY    (AEMPTY),
    .COUNT     (COUNT),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  // External RAM driven by the controller's addresses, 1-cycle registered read.
  logic [7:0] mem [D];
  logic [7:0] ram_q;
  logic [7:0] wdata;
  always @(posedge CLK) begin
    if (RAM_WE) mem[RAM_WADDR] <= wdata;
    if (RAM_RE) ram_q <= mem[RAM_RADDR];
  end

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents as a queue plus sticky error bits.
  int   q[$];
  bit   m_ovf, m_udf, m_vld;
  int   m_rdata;
  int   m_wr_total, m_rd_total;
  bit   exp_we, exp_re;
  int   exp_waddr, exp_raddr;
  logic obs_we, obs_re;
  logic [DB-1:0] obs_waddr, obs_raddr;

  // One clock of stimulus: sample the request-path outputs before the edge,
  // then advance the model and settle just after the edge.
  task automatic cycle(input bit wr, input bit rd, input bit clr, input bit rst,
                       input logic [7:0] wd);
    WR_EN = wr; RD_EN = rd; ERR_CLR = clr; RST = rst; wdata = wd;
    @(negedge CLK);
    obs_we = RAM_WE; obs_re = RAM_RE; obs_waddr = RAM_WADDR; obs_raddr = RAM_RADDR;
    exp_we = !rst && wr && (q.size() < D);
    exp_re = !rst && rd && (q.size() > 0);
    exp_waddr = m_wr_total % D;
    exp_raddr = m_rd_total % D;
    @(posedge CLK);
    if (rst) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_vld = 0; m_wr_total = 0; m_rd_total = 0;
    end else begin
      if (wr && q.size() == D) m_ovf = 1; else if (clr) m_ovf = 0;
      if (rd && q.size() == 0) m_udf = 1; else if (clr) m_udf = 0;
      m_vld = exp_re;
      if (exp_re) begin m_rdata = q.pop_front(); m_rd_total++; end
      if (exp_we) begin q.push_back(int'(wd)); m_wr_total++; end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 1, 8'h00);
    cycle(0, 0, 0, 1, 8'h00);
    cycle(0, 1, 0, 0, 8'h00);   // read on empty -> UNDERFLOW before the reset test
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, 8'(i));
    cycle(1, 1, 0, 0, 8'h55);   // read in flight at COUNT=7
    checks++; if (COUNT !== 5'd7 || UNDERFLOW !== 1'b1) begin errors++;
      $display("FAIL reset_pre count=%0d udf=%b required 7/1", COUNT, UNDERFLOW); end
    for (int i = 0; i < 2; i++) begin
      cycle(1, 1, 0, 1, 8'h66);
      checks++; if (obs_we !== 1'b0 || obs_re !== 1'b0) begin errors++;
        $display("FAIL reset_ram_en we=%b re=%b required 0/0", obs_we, obs_re); end
    end
    checks++; if ({COUNT, EMPTY, AEMPTY, FULL, AFULL} !== {5'd0, 4'b1100}) begin errors++;
      $display("FAIL reset_state count=%0d e=%b ae=%b f=%b af=%b required 0/1/1/0/0",
               COUNT, EMPTY, AEMPTY, FULL, AFULL); end
    checks++; if ({RD_VALID, OVERFLOW, UNDERFLOW} !== 3'b000) begin errors++;
      $display("FAIL reset_ctl vld=%b ovf=%b udf=%b required 000", RD_VALID, OVERFLOW, UNDERFLOW); end
    checks++; if (RAM_WADDR !== 4'd0 || RAM_RADDR !== 4'd0) begin errors++;
      $display("FAIL reset_addr waddr=%0d raddr=%0d required 0/0", RAM_WADDR, RAM_RADDR); end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= D; k++) begin
      cycle(1, 0, 0, 0, 8'(k - 1));
      checks++; if (obs_we !== 1'b1 || COUNT !== 5'(k)) begin errors++;
        $display("FAIL fill_write k=%0d we=%b count=%0d required 1/%0d", k, obs_we, COUNT, k); end
      checks++; if (AEMPTY !== (k <= AE) || AFULL !== (k >= AF) || FULL !== (k == D) || EMPTY !== 1'b0)
        begin errors++;
        $display("FAIL fill_flags k=%0d ae=%b af=%b f=%b e=%b", k, AEMPTY, AFULL, FULL, EMPTY); end
    end
    cycle(1, 0, 0, 0, 8'hAA);
    checks++; if (obs_we !== 1'b0 || OVERFLOW !== 1'b1 || COUNT !== 5'd16) begin errors++;
      $display("FAIL fill_over we=%b ovf=%b count=%0d required 0/1/16", obs_we, OVERFLOW, COUNT); end
    cycle(0, 0, 1, 0, 8'h00);
    checks++; if (OVERFLOW !== 1'b0) begin errors++;
      $display("FAIL fill_ovf_clr ovf=%b required 0", OVERFLOW); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < D; i++) begin
      cycle(0, 1, 0, 0, 8'h00);
      checks++; if (obs_re !== 1'b1 || RD_VALID !== 1'b1 || ram_q !== 8'(i)) begin errors++;
        $display("FAIL drain_data i=%0d re=%b vld=%b data=%0d required 1/1/%0d",
                 i, obs_re, RD_VALID, ram_q, i); end
      checks++; if (COUNT !== 5'(D - 1 - i) || EMPTY !== (i == D - 1)) begin errors++;
        $display("FAIL drain_count i=%0d count=%0d e=%b", i, COUNT, EMPTY); end
    end
    cycle(0, 1, 0, 0, 8'h00);
    checks++; if (obs_re !== 1'b0 || RD_VALID !== 1'b0 || UNDERFLOW !== 1'b1) begin errors++;
      $display("FAIL drain_under re=%b vld=%b udf=%b required 0/0/1", obs_re, RD_VALID, UNDERFLOW); end
    cycle(0, 0, 1, 0, 8'h00);
    checks++; if (UNDERFLOW !== 1'b0) begin errors++;
      $display("FAIL drain_udf_clr udf=%b required 0", UNDERFLOW); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < D; i++) cycle(1, 0, 0, 0, 8'($urandom));
    cycle(1, 1, 0, 0, 8'hEE);
    checks++; if (obs_we !== 1'b0 || obs_re !== 1'b1 || COUNT !== 5'd15 || OVERFLOW !== 1'b1)
      begin errors++;
      $display("FAIL simul_full we=%b re=%b count=%0d ovf=%b required 0/1/15/1",
               obs_we, obs_re, COUNT, OVERFLOW); end
    checks++; if (RD_VALID !== 1'b1 || ram_q !== 8'(m_rdata) || FULL !== 1'b0) begin errors++;
      $display("FAIL simul_full_rd vld=%b data=%0d f=%b required 1/%0d/0", RD_VALID, ram_q, FULL, m_rdata); end
    cycle(0, 0, 1, 0, 8'h00);
    while (q.size() > 0) cycle(0, 1, 0, 0, 8'h00);
    cycle(1, 1, 0, 0, 8'h3C);
    checks++; if (obs_we !== 1'b1 || obs_re !== 1'b0 || COUNT !== 5'd1 || UNDERFLOW !== 1'b1)
      begin errors++;
      $display("FAIL simul_empty we=%b re=%b count=%0d udf=%b required 1/0/1/1",
               obs_we, obs_re, COUNT, UNDERFLOW); end
    checks++; if (RD_VALID !== 1'b0 || EMPTY !== 1'b0) begin errors++;
      $display("FAIL simul_empty_rd vld=%b e=%b required 0/0", RD_VALID, EMPTY); end
    cycle(0, 0, 1, 0, 8'h00);
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 200; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), 0, 8'($urandom));
      checks++; if (obs_we !== exp_we || obs_re !== exp_re ||
                    obs_waddr !== 4'(exp_waddr) || obs_raddr !== 4'(exp_raddr)) begin errors++;
        $display("FAIL wrap_ram n=%0d we=%b re=%b wa=%0d ra=%0d required %b/%b/%0d/%0d",
                 n, obs_we, obs_re, obs_waddr, obs_raddr, exp_we, exp_re, exp_waddr, exp_raddr); end
      checks++; if (COUNT !== 5'(q.size()) || FULL !== (q.size() == D) || EMPTY !== (q.size() == 0) ||
                    AFULL !== (q.size() >= AF) || AEMPTY !== (q.size() <= AE)) begin errors++;
        $display("FAIL wrap_flags n=%0d count=%0d f=%b e=%b af=%b ae=%b required count %0d",
                 n, COUNT, FULL, EMPTY, AFULL, AEMPTY, q.size()); end
      checks++; if (OVERFLOW !== m_ovf || UNDERFLOW !== m_udf || RD_VALID !== m_vld) begin errors++;
        $display("FAIL wrap_ctl n=%0d ovf=%b udf=%b vld=%b required %b/%b/%b",
                 n, OVERFLOW, UNDERFLOW, RD_VALID, m_ovf, m_udf, m_vld); end
      if (m_vld) begin
        checks++; if (ram_q !== 8'(m_rdata)) begin errors++;
          $display("FAIL wrap_data n=%0d data=%0d required %0d", n, ram_q, m_rdata); end
      end
    end
  endtask

  task automatic test_stream();
    while (q.size() > 8) cycle(0, 1, 0, 0, 8'h00);
    while (q.size() < 8) cycle(1, 0, 0, 0, 8'($urandom));
    cycle(0, 0, 1, 0, 8'h00);
    for (int n = 0; n < 40; n++) begin
      cycle(1, 1, 0, 0, 8'($urandom));
      checks++; if (obs_we !== 1'b1 || obs_re !== 1'b1 || COUNT !== 5'd8 ||
                    {FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW} !== 6'b0) begin errors++;
        $display("FAIL stream_state n=%0d we=%b re=%b count=%0d f=%b e=%b af=%b ae=%b",
                 n, obs_we, obs_re, COUNT, FULL, EMPTY, AFULL, AEMPTY); end
      checks++; if (RD_VALID !== 1'b1 || ram_q !== 8'(m_rdata)) begin errors++;
        $display("FAIL stream_data n=%0d vld=%b data=%0d required 1/%0d", n, RD_VALID, ram_q, m_rdata); end
    end
  endtask

  initial begin
    RST = 1'b1; WR_EN = 1'b0; RD_EN = 1'b0; ERR_CLR = 1'b0; wdata = 8'h00;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
